// File: rtl/writeback_arbiter.sv
// Register-file write port arbiter: pipeline writeback has priority,
// long-latency results wait in a small FIFO and drain on idle cycles.
//
// Ports:
//   clock, reset                  rising-edge clock, async active-high reset
//   pipeWriteEnable/Address/Data  pipeline writeback request
//   unitValid/Address/Data        long-latency result offer
//   unitReady                     FIFO can accept this cycle
//   destinationEnable             register-file write strobe
//   writeAddress/writeData        register-file write address/data
//   pendingMask                   registers targeted by live FIFO entries
//   stallRequest                  ask pipeline for a writeback bubble
//   occupancy                     FIFO entry count, live and killed
module writeback_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          pipeWriteEnable,
  input  logic [4:0]    pipeWriteAddress,
  input  logic [31:0]   pipeWriteData,
  input  logic          unitValid,
  output logic          unitReady,
  input  logic [4:0]    unitAddress,
  input  logic [31:0]   unitData,
  output logic          destinationEnable,
  output logic [4:0]    writeAddress,
  output logic [31:0]   writeData,
  output logic [31:0]   pendingMask,
  output logic          stallRequest,
  output logic [CW-1:0] occupancy
);

  logic [FIFO_DEPTH-1:0] live_q, live_d;
  logic [4:0]            addr_q [FIFO_DEPTH];
  logic [31:0]           data_q [FIFO_DEPTH];
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [3:0]            starve_q, starve_d;
  logic                  stall_q, stall_d;

  logic empty, headLive, pipeWins;
  logic enq, pop, blocked;

  assign empty     = (count_q == '0);
  assign headLive  = !empty && live_q[head_q];
  assign pipeWins  = pipeWriteEnable &&
                     (pipeWriteAddress != 5'd0);
  assign unitReady = (count_q != CW'(FIFO_DEPTH));
  // x0 results finish the handshake but never occupy a slot
  assign enq       = unitValid && unitReady &&
                     (unitAddress != 5'd0);
  // a killed head leaves even when the pipeline owns the port
  assign pop       = !empty && !(headLive && pipeWins);
  assign blocked   = headLive && pipeWins;

  assign occupancy    = count_q;
  assign stallRequest = stall_q;

  always_comb begin
    destinationEnable = 1'b0;
    writeAddress      = 5'd0;
    writeData         = 32'd0;
    if (pipeWins) begin
      destinationEnable = 1'b1;
      writeAddress      = pipeWriteAddress;
      writeData         = pipeWriteData;
    end else if (headLive) begin
      destinationEnable = 1'b1;
      writeAddress      = addr_q[head_q];
      writeData         = data_q[head_q];
    end
  end

  always_comb begin
    pendingMask = 32'd0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (live_q[i]) pendingMask[addr_q[i]] = 1'b1;
    end
  end

  always_comb begin
    live_d = live_q;
    // the younger pipeline value supersedes queued ones
    if (pipeWins) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (addr_q[i] == pipeWriteAddress) live_d[i] = 1'b0;
      end
    end
    if (pop) live_d[head_q] = 1'b0;
    // applied last so a same-cycle enqueue survives the kill
    if (enq) live_d[tail_q] = 1'b1;

    head_d = pop ? head_q + PW'(1) : head_q;
    tail_d = enq ? tail_q + PW'(1) : tail_q;

    count_d = count_q;
    if (enq && !pop) count_d = count_q + CW'(1);
    if (!enq && pop) count_d = count_q - CW'(1);

    starve_d = starve_q;
    if (empty || pop) begin
      starve_d = 4'd0;
    end else if (blocked &&
                 starve_q != 4'(STARVE_LIMIT)) begin
      starve_d = starve_q + 4'd1;
    end
    stall_d = (starve_d == 4'(STARVE_LIMIT));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      live_q   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= 4'd0;
      stall_q  <= 1'b0;
    end else begin
      live_q   <= live_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  // payload needs no reset: live bits gate every use
  always_ff @(posedge clock) begin
    if (enq) begin
      addr_q[tail_q] <= unitAddress;
      data_q[tail_q] <= unitData;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter.
// Inputs change 1ns after posedge, outputs checked at negedge.
module tb_writeback_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        pipeWriteEnable;
  logic [4:0]  pipeWriteAddress;
  logic [31:0] pipeWriteData;
  logic        unitValid;
  logic        unitReady;
  logic [4:0]  unitAddress;
  logic [31:0] unitData;
  logic        destinationEnable;
  logic [4:0]  writeAddress;
  logic [31:0] writeData;
  logic [31:0] pendingMask;
  logic        stallRequest;
  logic [1:0]  occupancy;

  int compared = 0;
  int mismatched = 0;

  writeback_arbiter #(
    .FIFO_DEPTH(2),
    .STARVE_LIMIT(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pipeWriteEnable(pipeWriteEnable),
    .pipeWriteAddress(pipeWriteAddress),
    .pipeWriteData(pipeWriteData),
    .unitValid(unitValid),
    .unitReady(unitReady),
    .unitAddress(unitAddress),
    .unitData(unitData),
    .destinationEnable(destinationEnable),
    .writeAddress(writeAddress),
    .writeData(writeData),
    .pendingMask(pendingMask),
    .stallRequest(stallRequest),
    .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic port(input string tag,
                      input logic en,
                      input logic [4:0] a,
                      input logic [31:0] d);
    chk({tag, ".en"}, 32'(destinationEnable), 32'(en));
    chk({tag, ".wa"}, 32'(writeAddress), 32'(a));
    chk({tag, ".wd"}, writeData, d);
  endtask

  task automatic pipe(input logic en,
                      input logic [4:0] a,
                      input logic [31:0] d);
    pipeWriteEnable  = en;
    pipeWriteAddress = a;
    pipeWriteData    = d;
  endtask

  task automatic unit(input logic v,
                      input logic [4:0] a,
                      input logic [31:0] d);
    unitValid   = v;
    unitAddress = a;
    unitData    = d;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic mid;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    pipe(1'b0, 5'd0, 32'd0);
    unit(1'b0, 5'd0, 32'd0);
    #2;
    chk("rst.occ", 32'(occupancy), 32'd0);
    chk("rst.ready", 32'(unitReady), 32'd1);
    chk("rst.mask", pendingMask, 32'd0);
    chk("rst.stall", 32'(stallRequest), 32'd0);
    port("rst", 1'b0, 5'd0, 32'd0);
    tick; tick;
    reset = 1'b0;

    // idle port
    unit(1'b1, 5'd5, 32'hDEADBEEF);
    mid;
    port("idle.c0", 1'b0, 5'd0, 32'd0);
    tick;
    unit(1'b0, 5'd0, 32'd0);
    mid;
    port("idle.c1", 1'b1, 5'd5, 32'hDEADBEEF);
    chk("idle.c1.mask", pendingMask, 32'h0000_0020);
    chk("idle.c1.occ", 32'(occupancy), 32'd1);
    tick;
    mid;
    port("idle.c2", 1'b0, 5'd0, 32'd0);
    chk("idle.c2.mask", pendingMask, 32'd0);
    chk("idle.c2.occ", 32'(occupancy), 32'd0);
    tick;

    // conflict: pipeline holds the port for 3 cycles
    pipe(1'b1, 5'd3, 32'h33);
    unit(1'b1, 5'd7, 32'h77);
    mid;
    port("cf.c0", 1'b1, 5'd3, 32'h33);
    tick;
    unit(1'b0, 5'd0, 32'd0);
    pipe(1'b1, 5'd3, 32'h34);
    mid;
    port("cf.c1", 1'b1, 5'd3, 32'h34);
    chk("cf.c1.mask", pendingMask, 32'h0000_0080);
    tick;
    pipe(1'b1, 5'd3, 32'h35);
    mid;
    port("cf.c2", 1'b1, 5'd3, 32'h35);
    chk("cf.c2.stall", 32'(stallRequest), 32'd0);
    tick;
    pipe(1'b0, 5'd0, 32'd0);
    mid;
    port("cf.c3", 1'b1, 5'd7, 32'h77);
    chk("cf.c3.stall", 32'(stallRequest), 32'd0);
    tick;
    mid;
    port("cf.c4", 1'b0, 5'd0, 32'd0);
    chk("cf.c4.occ", 32'(occupancy), 32'd0);
    chk("cf.c4.stall", 32'(stallRequest), 32'd0);
    tick;

    // starvation
    pipe(1'b1, 5'd1, 32'h100);
    unit(1'b1, 5'd7, 32'hA7);
    tick;
    unit(1'b0, 5'd0, 32'd0);
    for (int c = 1; c <= 4; c++) begin
      pipe(1'b1, 5'd1, 32'h100 + 32'(c));
      mid;
      chk($sformatf("sv.c%0d.stall", c),
          32'(stallRequest), 32'd0);
      chk($sformatf("sv.c%0d.wa", c),
          32'(writeAddress), 32'd1);
      tick;
    end
    pipe(1'b1, 5'd1, 32'h105);
    mid;
    chk("sv.c5.stall", 32'(stallRequest), 32'd1);
    port("sv.c5", 1'b1, 5'd1, 32'h105);
    tick;
    pipe(1'b0, 5'd0, 32'd0);
    mid;
    port("sv.c6", 1'b1, 5'd7, 32'hA7);
    chk("sv.c6.stall", 32'(stallRequest), 32'd1);
    tick;
    mid;
    chk("sv.c7.stall", 32'(stallRequest), 32'd0);
    chk("sv.c7.occ", 32'(occupancy), 32'd0);
    port("sv.c7", 1'b0, 5'd0, 32'd0);
    tick;

    // WAW kill
    pipe(1'b1, 5'd1, 32'h200);
    unit(1'b1, 5'd9, 32'h11);
    tick;
    unit(1'b0, 5'd0, 32'd0);
    pipe(1'b1, 5'd9, 32'h22);
    mid;
    port("waw.c1", 1'b1, 5'd9, 32'h22);
    chk("waw.c1.mask", pendingMask, 32'h0000_0200);
    tick;
    pipe(1'b0, 5'd0, 32'd0);
    mid;
    port("waw.c2", 1'b0, 5'd0, 32'd0);
    chk("waw.c2.mask", pendingMask, 32'd0);
    chk("waw.c2.occ", 32'(occupancy), 32'd1);
    tick;
    mid;
    port("waw.c3", 1'b0, 5'd0, 32'd0);
    chk("waw.c3.occ", 32'(occupancy), 32'd0);
    tick;

    // same-cycle enqueue and kill of one address
    pipe(1'b1, 5'd1, 32'h300);
    unit(1'b1, 5'd13, 32'hD0);
    tick;
    pipe(1'b1, 5'd13, 32'hE0);
    unit(1'b1, 5'd13, 32'hD1);
    tick;
    pipe(1'b0, 5'd0, 32'd0);
    unit(1'b0, 5'd0, 32'd0);
    mid;
    port("ek.c2", 1'b0, 5'd0, 32'd0);
    chk("ek.c2.mask", pendingMask, 32'h0000_2000);
    chk("ek.c2.occ", 32'(occupancy), 32'd2);
    tick;
    mid;
    port("ek.c3", 1'b1, 5'd13, 32'hD1);
    tick;
    mid;
    chk("ek.c4.occ", 32'(occupancy), 32'd0);
    tick;

    // full FIFO and x0 unit write
    pipe(1'b1, 5'd1, 32'h400);
    unit(1'b1, 5'd10, 32'hA0);
    tick;
    unit(1'b1, 5'd11, 32'hB0);
    mid;
    chk("full.c1.ready", 32'(unitReady), 32'd1);
    chk("full.c1.occ", 32'(occupancy), 32'd1);
    tick;
    unit(1'b1, 5'd12, 32'hC0);
    mid;
    chk("full.c2.ready", 32'(unitReady), 32'd0);
    chk("full.c2.occ", 32'(occupancy), 32'd2);
    chk("full.c2.mask", pendingMask, 32'h0000_0C00);
    tick;
    pipe(1'b0, 5'd0, 32'd0);
    mid;
    chk("full.c3.ready", 32'(unitReady), 32'd0);
    port("full.c3", 1'b1, 5'd10, 32'hA0);
    tick;
    mid;
    chk("full.c4.ready", 32'(unitReady), 32'd1);
    port("full.c4", 1'b1, 5'd11, 32'hB0);
    tick;
    pipe(1'b1, 5'd1, 32'h401);
    unit(1'b1, 5'd0, 32'hFF);
    mid;
    chk("x0.c5.ready", 32'(unitReady), 32'd1);
    chk("x0.c5.occ", 32'(occupancy), 32'd1);
    port("x0.c5", 1'b1, 5'd1, 32'h401);
    tick;
    pipe(1'b0, 5'd0, 32'd0);
    unit(1'b0, 5'd0, 32'd0);
    mid;
    chk("x0.c6.occ", 32'(occupancy), 32'd1);
    chk("x0.c6.mask", pendingMask, 32'h0000_1000);
    port("x0.c6", 1'b1, 5'd12, 32'hC0);
    tick;
    mid;
    chk("x0.c7.occ", 32'(occupancy), 32'd0);
    port("x0.c7", 1'b0, 5'd0, 32'd0);
    tick;

    // async reset with two entries queued
    pipe(1'b1, 5'd1, 32'h500);
    unit(1'b1, 5'd20, 32'h20);
    tick;
    unit(1'b1, 5'd21, 32'h21);
    tick;
    unit(1'b0, 5'd0, 32'd0);
    #1;
    chk("ar.pre.occ", 32'(occupancy), 32'd2);
    #1;
    reset = 1'b1;
    #1;
    chk("ar.occ", 32'(occupancy), 32'd0);
    chk("ar.mask", pendingMask, 32'd0);
    chk("ar.ready", 32'(unitReady), 32'd1);
    chk("ar.stall", 32'(stallRequest), 32'd0);
    pipe(1'b0, 5'd0, 32'd0);
    #1;
    port("ar.in", 1'b0, 5'd0, 32'd0);
    tick;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      mid;
      port($sformatf("ar.post%0d", c),
           1'b0, 5'd0, 32'd0);
      tick;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
